// File: rtl/seg7_pkg.sv
// seg7_pkg: scan slot states and active-high segment patterns (bit0=a .. bit6=g)
package seg7_pkg;
  typedef enum logic [1:0] {S_UNI, S_DEC, S_CEN} slot_t;
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111100;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1100111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: BCD to seven-segment decode; codes 10..15 render dark
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 3-digit multiplexed 7-seg driver with frame-synchronous updates.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading-zero hundreds/tens digits.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cen,
  input  logic [3:0] dec,
  input  logic [3:0] uni,
  input  logic       upd,
  output logic       ack,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt, cnt_n;
  slot_t slot, slot_n;
  logic run, pend, bnd, lit_c, lit_d;
  logic [11:0] sh, sh_n, pv;
  logic [3:0] dig;
  logic [2:0] an_n;
  logic [6:0] seg_d;
  // outputs are registered from next-state values so an/seg line up with cnt;
  // run holds cnt at 0 for the first clock after reset so frame pulses there
  always_comb begin
    bnd = slot == S_CEN && cnt == LAST;
    cnt_n = (!run || cnt == LAST) ? '0 : cnt + 1'b1;
    slot_n = (!run || cnt != LAST) ? slot : slot == S_UNI ? S_DEC : slot == S_DEC ? S_CEN : S_UNI;
    sh_n = !bnd ? sh : upd ? {cen, dec, uni} : pend ? pv : sh;
`ifdef LEADING_ZERO_BLANK_EN
    lit_c = sh_n[11:8] != 4'd0;
    lit_d = lit_c || sh_n[7:4] != 4'd0;
`else
    lit_c = 1'b1;
    lit_d = 1'b1;
`endif
    an_n = int'(cnt_n) < BLANK ? 3'b000 :
           slot_n == S_UNI ? 3'b001 :
           slot_n == S_DEC ? {1'b0, lit_d, 1'b0} : {lit_c, 2'b00};
    dig = slot_n == S_UNI ? sh_n[3:0] : slot_n == S_DEC ? sh_n[7:4] : sh_n[11:8];
  end
  assign ack = bnd && (upd || pend);
  seg7_dec u_dec (.bcd(dig), .seg(seg_d));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      slot  <= S_UNI;
      sh    <= '0;
      pv    <= '0;
      pend  <= 1'b0;
      an    <= 3'b000;
      seg   <= SEG_OFF;
      frame <= 1'b0;
    end else begin
      run   <= 1'b1;
      cnt   <= cnt_n;
      slot  <= slot_n;
      sh    <= sh_n;
      pv    <= (upd && !bnd) ? {cen, dec, uni} : pv;
      pend  <= bnd ? 1'b0 : upd ? 1'b1 : pend;
      an    <= an_n;
      seg   <= an_n == 3'b000 ? SEG_OFF : seg_d;
      frame <= slot_n == S_UNI && cnt_n == '0;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized + directed check of seg7_scan (DIV=8, BLANK=2)
// against a frame-position model; honours LEADING_ZERO_BLANK_EN if defined.
module tb_seg7_scan;
  logic clk = 1'b0, rst_n = 1'b0, upd = 1'b0;
  logic [3:0] cen = '0, dec = '0, uni = '0;
  logic ack, frame;
  logic [2:0] an;
  logic [6:0] seg;
  int checks = 0, errors = 0;
  int p = -1;
  int sh[3] = '{0, 0, 0};
  int pv[3] = '{0, 0, 0};
  bit pend = 0;
  logic [6:0] tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};

  seg7_scan #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dec(dec), .uni(uni), .upd(upd),
    .ack(ack), .an(an), .seg(seg), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at pos %0d: got %b want %b", tag, p, obs, exp);
    end
  endtask

  function automatic bit lit(input int s);
`ifdef LEADING_ZERO_BLANK_EN
    return s == 2 ? sh[2] != 0 : s == 1 ? (sh[2] != 0 || sh[1] != 0) : 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk_all();
    int s;
    logic [6:0] ea, es;
    s = p < 0 ? 0 : p / 8;
    ea = (p < 0 || p % 8 < 2 || !lit(s)) ? 7'd0 : 7'(1 << s);
    es = ea == 0 ? 7'd0 : sh[s] < 10 ? tbl[sh[s]] : 7'd0;
    chk("an", 7'(an), ea);
    chk("seg", seg, es);
    chk("frame", 7'(frame), 7'(p == 0));
  endtask

  task automatic step(input bit u, input int c, input int d, input int n);
    @(negedge clk);
    upd = u; cen = 4'(c); dec = 4'(d); uni = 4'(n);
    #1 chk("ack", 7'(ack), 7'(rst_n && p == 23 && (u || pend)));
    @(posedge clk);
    if (rst_n) begin
      if (p == 23) begin
        if (u) sh = '{n, d, c};
        else if (pend) sh = pv;
        pend = 0;
      end else if (u) begin
        pv = '{n, d, c};
        pend = 1;
      end
      p = (p + 1) % 24;
    end
    #1 chk_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < 30 && p != t; i++) step(0, 0, 0, 0);
    checks++;
    assert (p == t) else begin
      errors++;
      $error("FAIL run_to: got pos %0d want %0d", p, t);
    end
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(48);
    run_to(4);
    step(1, 1, 2, 8);
    idle(48);
    run_to(2);
    step(1, 1, 2, 3);
    idle(3);
    step(1, 0, 4, 5);
    idle(48);
    step(1, 0, 0, 7);
    idle(48);
    run_to(22);
    step(1, 2, 3, 11);
    idle(24);
    run_to(22);
    step(1, 11, 0, 4);
    idle(24);
    for (int i = 0; i < 400; i++)
      step($urandom_range(7) == 0, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    run_to(9);
    step(1, 9, 6, 5);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    p = -1; sh = '{0, 0, 0}; pv = '{0, 0, 0}; pend = 0;
    chk("rst_ack", 7'(ack), 7'd0);
    chk_all();
    idle(2);
    rst_n = 1'b1;
    idle(48);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV, default 1000, clock cycles per digit slot; legal range DIV >= 2.
REQ-002 Parameter BLANK, default 50, dark cycles at the start of each slot (anti-ghosting); legal range 0 <= BLANK < DIV.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cen  input  4  BCD hundreds digit from the binary-to-BCD stage.
REQ-006 dec  input  4  BCD tens digit.
REQ-007 uni  input  4  BCD units digit.
REQ-008 upd  input  1  one-cycle strobe: cen/dec/uni are valid, capture them.
REQ-009 ack  output  1  one-cycle pulse: a captured value has been applied to the display.
REQ-010 an  output  3  one-hot digit enable, active-high; an[0]=units, an[1]=tens, an[2]=hundreds.
REQ-011 seg  output  7  segment drive, active-high, bit0=a ... bit6=g.
REQ-012 frame  output  1  one-cycle pulse on the first cycle of each units slot.

Function
REQ-013 Prescaler cnt counts 0..DIV-1 and wraps; slot FSM S_UNI -> S_DEC -> S_CEN -> S_UNI advances on the cycle cnt==DIV-1; a frame lasts 3*DIV cycles.
REQ-014 an is 000 while cnt < BLANK; for cnt >= BLANK, an is the one-hot bit of the current slot; an and seg are registers aligned with cnt, with no combinational glitch.
REQ-015 seg is 0000000 whenever an==000; otherwise seg is the decode of the current slot's shadow digit.
REQ-016 Decode table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111.
REQ-017 Codes 10..15 decode to 0000000, with the digit enable still asserted.
REQ-018 On upd, cen/dec/uni are latched into a pending register and a pending flag is set; a later upd before application overwrites it, so the last value wins.
REQ-019 The pending value is copied to the shadow digits on the frame-boundary cycle (S_CEN, cnt==DIV-1); ack pulses on that same cycle and the pending flag clears.
REQ-020 upd coinciding with the frame-boundary cycle: that cycle's inputs go directly to the shadow digits and ack pulses; the pending flag stays clear.
REQ-021 The shadow digits never change mid-frame, so all three digits in a frame come from one upd.
REQ-022 frame is high exactly when slot==S_UNI and cnt==0.

Reset
REQ-023 While rst_n=0: cnt=0, slot=S_UNI, shadow and pending digits=0, pending flag=0, an=000, seg=0000000, ack=0, frame=0.
REQ-024 The first clock after reset release is slot S_UNI, cnt=0; frame pulses at that point.
REQ-025 Reset asserted mid-frame discards any pending value with no ack.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN, when defined: the hundreds digit is dark (an[2] stays 0) if shadow cen==0.
REQ-027 Under LEADING_ZERO_BLANK_EN, the tens digit is also dark (an[1] stays 0) if shadow cen==0 and dec==0.
REQ-028 Under LEADING_ZERO_BLANK_EN, the units digit is always lit, and slot timing is unchanged.
REQ-029 Without LEADING_ZERO_BLANK_EN, all three digits are always lit per REQ-014.

Structure
REQ-030 A shared package seg7_pkg holds the slot-state enum (S_UNI, S_DEC, S_CEN) and the segment pattern constants SEG_0..SEG_9 and SEG_OFF.
REQ-031 One combinational sub-module, seg7_dec (4-bit BCD in, 7-bit seg out), implements REQ-016 and REQ-017.

Verification (DIV=8, BLANK=2)
REQ-032 Reset release, no upd -> frame at cycle 0; an=000 for cnt 0..1; an=001 for cnt 2..7 with seg=0111111; then an=010 and an=100 in turn; period 24 cycles.
REQ-033 upd with cen=1, dec=2, uni=8 mid-frame -> display unchanged until the boundary; ack there; next frame units=1111111, tens=1011011, hundreds=0000110.
REQ-034 Two upds in one frame (123, then 045) -> a single ack; next frame shows 0/4/5; with LEADING_ZERO_BLANK_EN, an[2] is never asserted.
REQ-035 Value 007 with LEADING_ZERO_BLANK_EN -> only an[0] is ever asserted, seg=0000111; without the macro, tens and hundreds show 0111111.
REQ-036 upd exactly on the boundary cycle with digit 11 -> ack on the same cycle; that digit's slot has its an bit asserted with seg=0000000.
REQ-037 rst_n pulled low mid-slot with an update pending -> all outputs 0 asynchronously; no ack; restart per REQ-024 showing 000.
